// File: rtl/dma_master.sv
// AXI4 initiator for the DMA engine: copies DMALEN words from DMASRC to DMADST
// as read-burst / write-burst pairs through a MAX_BEATS-deep word buffer.
module dma_master #(
    parameter logic [3:0] DMA_ID    = 4'd2,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMAEN,
    input  logic [31:0] DMASRC,
    input  logic [31:0] DMADST,
    input  logic [31:0] DMALEN,
    output logic        DMA_interrupt,
    output logic        DMA_err,
    output logic [3:0]  M_ARID,
    output logic [31:0] M_ARAddr,
    output logic [3:0]  M_ARLen,
    output logic [2:0]  M_ARSize,
    output logic [1:0]  M_ARBurst,
    output logic        M_ARValid,
    input  logic        M_ARReady,
    input  logic [3:0]  M_RID,
    input  logic [31:0] M_RData,
    input  logic [1:0]  M_RResp,
    input  logic        M_RLast,
    input  logic        M_RValid,
    output logic        M_RReady,
    output logic [3:0]  M_AWID,
    output logic [31:0] M_AWAddr,
    output logic [3:0]  M_AWLen,
    output logic [2:0]  M_AWSize,
    output logic [1:0]  M_AWBurst,
    output logic        M_AWValid,
    input  logic        M_AWReady,
    output logic [31:0] M_WData,
    output logic [3:0]  M_WStrb,
    output logic        M_WLast,
    output logic        M_WValid,
    input  logic        M_WReady,
    input  logic [3:0]  M_BID,
    input  logic [1:0]  M_BResp,
    input  logic        M_BValid,
    output logic        M_BReady
);
    localparam int CW = $clog2(MAX_BEATS);
    localparam int BW = CW + 1;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_t;

    state_t          state_r;
    logic [31:0]     src_r;
    logic [31:0]     dst_r;
    logic [31:0]     rem_r;
    logic [BW-1:0]   beats_r;
    logic [CW-1:0]   rcnt_r;
    logic [CW-1:0]   wcnt_r;
    logic            ar_valid_r;
    logic            r_ready_r;
    logic            aw_valid_r;
    logic            w_valid_r;
    logic            b_ready_r;
    logic            irq_r;
    logic            err_r;
    logic [31:0]     data_buf_r [MAX_BEATS];

    logic [31:0]     src_first_s;
    logic [31:0]     dst_first_s;
    logic [31:0]     src_next_s;
    logic [31:0]     dst_next_s;
    logic [31:0]     rem_next_s;
    logic [BW-1:0]   first_beats_s;
    logic [BW-1:0]   next_beats_s;
    logic [BW-1:0]   last_idx_s;
    logic            r_fire_s;
    logic            err_next_s;
    logic            unused_ids_s;

    // Burst length: limited by remaining words, buffer depth and both 4KB pages.
    function automatic logic [BW-1:0] burst_beats(input logic [31:0] rem,
                                                  input logic [9:0]  src_word,
                                                  input logic [9:0]  dst_word);
        logic [31:0] n;
        logic [31:0] src_room;
        logic [31:0] dst_room;
        src_room = 32'd1024 - {22'd0, src_word};
        dst_room = 32'd1024 - {22'd0, dst_word};
        n = 32'(MAX_BEATS);
        if (rem < n) n = rem;
        if (src_room < n) n = src_room;
        if (dst_room < n) n = dst_room;
        return n[BW-1:0];
    endfunction

    assign src_first_s   = DMASRC & 32'hFFFF_FFFC;
    assign dst_first_s   = DMADST & 32'hFFFF_FFFC;
    assign src_next_s    = src_r + 32'({beats_r, 2'b00});
    assign dst_next_s    = dst_r + 32'({beats_r, 2'b00});
    assign rem_next_s    = rem_r - 32'(beats_r);
    assign first_beats_s = burst_beats(DMALEN, src_first_s[11:2], dst_first_s[11:2]);
    assign next_beats_s  = burst_beats(rem_next_s, src_next_s[11:2], dst_next_s[11:2]);
    assign last_idx_s    = beats_r - BW'(1);
    assign r_fire_s      = r_ready_r & M_RValid;
    assign err_next_s    = err_r | (M_BResp != 2'b00);
    assign unused_ids_s  = ^{M_RID, M_BID};

    assign M_ARID        = DMA_ID;
    assign M_ARAddr      = src_r;
    assign M_ARLen       = last_idx_s[3:0];
    assign M_ARSize      = 3'b010;
    assign M_ARBurst     = 2'b01;
    assign M_ARValid     = ar_valid_r;
    assign M_RReady      = r_ready_r;
    assign M_AWID        = DMA_ID;
    assign M_AWAddr      = dst_r;
    assign M_AWLen       = last_idx_s[3:0];
    assign M_AWSize      = 3'b010;
    assign M_AWBurst     = 2'b01;
    assign M_AWValid     = aw_valid_r;
    assign M_WData       = data_buf_r[wcnt_r];
    assign M_WStrb       = 4'hF;
    assign M_WLast       = ({1'b0, wcnt_r} == last_idx_s);
    assign M_WValid      = w_valid_r;
    assign M_BReady      = b_ready_r;
    assign DMA_interrupt = irq_r;
    assign DMA_err       = err_r;

    // Read beats land in the word buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (r_fire_s) data_buf_r[rcnt_r] <= M_RData;
    end

    // Copy sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            src_r      <= 32'd0;
            dst_r      <= 32'd0;
            rem_r      <= 32'd0;
            beats_r    <= '0;
            rcnt_r     <= '0;
            wcnt_r     <= '0;
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            b_ready_r  <= 1'b0;
            irq_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (DMAEN) begin
                    src_r <= src_first_s;
                    dst_r <= dst_first_s;
                    rem_r <= DMALEN;
                    if (DMALEN == 32'd0) begin
                        irq_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        err_r      <= 1'b0;
                        beats_r    <= first_beats_s;
                        ar_valid_r <= 1'b1;
                        state_r    <= RADDR;
                    end
                end
                RADDR: if (M_ARReady) begin
                    ar_valid_r <= 1'b0;
                    r_ready_r  <= 1'b1;
                    rcnt_r     <= '0;
                    state_r    <= RDATA;
                end
                RDATA: if (M_RValid) begin
                    rcnt_r <= rcnt_r + CW'(1);
                    if (M_RResp != 2'b00) err_r <= 1'b1;
                    if (M_RLast) begin
                        r_ready_r  <= 1'b0;
                        aw_valid_r <= 1'b1;
                        state_r    <= WADDR;
                    end
                end
                WADDR: if (M_AWReady) begin
                    aw_valid_r <= 1'b0;
                    w_valid_r  <= 1'b1;
                    wcnt_r     <= '0;
                    state_r    <= WDATA;
                end
                WDATA: if (M_WReady) begin
                    wcnt_r <= wcnt_r + CW'(1);
                    if (M_WLast) begin
                        w_valid_r <= 1'b0;
                        b_ready_r <= 1'b1;
                        state_r   <= WRESP;
                    end
                end
                WRESP: if (M_BValid) begin
                    b_ready_r <= 1'b0;
                    err_r     <= err_next_s;
                    src_r     <= src_next_s;
                    dst_r     <= dst_next_s;
                    rem_r     <= rem_next_s;
                    if (rem_next_s == 32'd0 || err_next_s) begin
                        irq_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        beats_r    <= next_beats_s;
                        ar_valid_r <= 1'b1;
                        state_r    <= RADDR;
                    end
                end
                DONE: if (!DMAEN) begin
                    irq_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dma_master.md
Name: dma_master

Overview:
- AXI4 initiator half of the DMA engine: copies DMALEN 32-bit words from DMASRC to DMADST.
- Driven by the DMA config registers (DMAEN/DMASRC/DMADST/DMALEN); raises an interrupt when the copy finishes.
- Sits on a master port of the AXI bridge, next to the CPU masters.
- Each copy runs as read burst into a 16-entry word buffer, then write burst out of it, repeated until the length is exhausted.

Parameters:
- DMA_ID, 4'd2: constant ARID/AWID driven on every transaction.
- MAX_BEATS, 16: maximum beats per burst; also the buffer depth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- DMAEN / DMASRC / DMADST / DMALEN  in  1/32/32/32  config: enable, source byte address, destination byte address, word count.
- DMA_interrupt  out  1  copy complete.
- DMA_err  out  1  sticky error flag: a non-OKAY RResp/BResp was seen during the copy.
- M_ARID / M_ARAddr / M_ARLen / M_ARSize / M_ARBurst  out  4/32/4/3/2  read address.
- M_ARValid  out  1;  M_ARReady  in  1.
- M_RID / M_RData / M_RResp / M_RLast / M_RValid  in  4/32/2/1/1;  M_RReady  out  1.
- M_AWID / M_AWAddr / M_AWLen / M_AWSize / M_AWBurst  out  4/32/4/3/2  write address.
- M_AWValid  out  1;  M_AWReady  in  1.
- M_WData / M_WStrb / M_WLast / M_WValid  out  32/4/1/1;  M_WReady  in  1.
- M_BID / M_BResp / M_BValid  in  4/2/1;  M_BReady  out  1.

Behaviour:
- Reset (async, rst=0): FSM returns to IDLE immediately, even mid-transfer. All Valid/Ready outputs, DMA_interrupt, DMA_err and internal counters go to 0. No bus handshake is completed after reset.
- Fixed fields: ARSize/AWSize = 3'b010. ARBurst/AWBurst = 2'b01 (INCR). WStrb = 4'hF. IDs = DMA_ID. Address bits [1:0] are forced to 0.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE: when DMAEN=1, latch src, dst and remaining (rem) = DMALEN.
  - If DMALEN=0, go to DONE.
  - Otherwise go to RADDR and clear DMA_err.
- Burst sizing, computed on entry to RADDR: beats = min(rem, MAX_BEATS, words to the next 4KB boundary of src, words to the next 4KB boundary of dst). ARLen = AWLen = beats-1. No burst ever crosses a 4KB boundary.
- RADDR: ARValid=1 (registered) until ARValid & ARReady, then go to RDATA. AR fields stay stable while Valid is high.
- RDATA: RReady=1. Each RValid & RReady writes RData into buf[rcnt], then rcnt++. A beat with RResp!=OKAY sets DMA_err. Go to WADDR on the handshake where RLast=1. RLast is trusted; beats beyond the requested length are not expected.
- WADDR: AWValid=1 until the AW handshake, then go to WDATA.
- WDATA: WValid=1, WData=buf[wcnt], WLast = (wcnt==beats-1). Each handshake increments wcnt. The handshake with WLast=1 goes to WRESP. WData and WLast are held stable while WValid=1 and WReady=0.
- WRESP: BReady=1. On BValid: BResp!=OKAY sets DMA_err; src += 4*beats; dst += 4*beats; rem -= beats.
  - If rem==0 or DMA_err=1, go to DONE.
  - Otherwise go to RADDR.
- DONE: DMA_interrupt=1 (registered). It holds until DMAEN=0, then the FSM goes to IDLE and DMA_interrupt returns to 0 the next cycle.
- DMAEN changes and config writes are ignored outside IDLE; an in-flight copy always runs to completion or to the error stop.
- There is never more than one outstanding transaction. AR and AW are never issued concurrently.
- rem and addresses are 32-bit; addresses wrap modulo 2^32 with no special handling.

Test Plan:
- Single burst: SRC=0x1000, DST=0x2000, LEN=4, zero-wait slave → one AR (Addr 0x1000, Len 3), 4 R beats, one AW (Addr 0x2000, Len 3), 4 W beats with the same data and WLast on beat 4, one B, then DMA_interrupt=1. Deasserting DMAEN clears the interrupt one cycle later.
- Multi-burst: LEN=37 → bursts of 16/16/5 (ARLen 15/15/4). Addresses step by 0x40. Total of 37 words written in order.
- 4KB split: SRC=0x0FF8, DST=0x3000, LEN=8 → first burst 2 beats (ARLen 1), second burst 6 beats from 0x1000 / 0x3008.
- Backpressure: random deassertion of ARReady/AWReady/WReady/BValid/RValid → Valid outputs and payload held stable; data integrity preserved.
- Error and zero length: BResp=SLVERR on the first of 3 bursts → DMA_err=1, DONE after that burst. Separately, LEN=0 → DONE the cycle after DMAEN with no bus activity.
- Reset mid-WDATA (rst low for 1 cycle) → WValid=0 immediately; IDLE; DMA_interrupt=0. A restart with DMAEN re-issues from DMASRC.
